// File: rtl/fb_pkg.sv
// Framebuffer address map, geometry and FSM state encoding.
// The framebuffer writer and the scanout reader both use this package.
package fb_pkg;

   localparam logic [10:0] FB_BASE_ADDR = 11'b1001_0000_000;
   localparam int LINE_LEN     = 9;
   localparam int COL_LEN      = 10;
   localparam int H_ACTIVE     = 640;
   localparam int V_ACTIVE     = 480;
   localparam int C_MST_AWIDTH = 32;
   localparam int C_MST_DWIDTH = 32;

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      WAIT_DATA,
      ERR,
      PUSH,
      DONE
   } fb_state_t;

   // PLB bit 0 is the MSB, so the base occupies addr[31:21].
   function automatic logic [C_MST_AWIDTH-1:0] fb_addr(input logic [LINE_LEN-1:0] line,
                                                       input logic [COL_LEN-1:0]  col);
      return {FB_BASE_ADDR, line, col, 2'b00};
   endfunction

endpackage

// File: rtl/fb_scan_counter.sv
// Raster position counter for the scanout walk.
// The next position is exported so the requester can register the next address early.
module fb_scan_counter
   import fb_pkg::*;
#(
   parameter int H_ACTIVE = fb_pkg::H_ACTIVE,
   parameter int V_ACTIVE = fb_pkg::V_ACTIVE
) (
   input  logic                PLB_clk,
   input  logic                reset_n,
   input  logic                clr,
   input  logic                inc,
   output logic [LINE_LEN-1:0] line,
   output logic [COL_LEN-1:0]  col,
   output logic [LINE_LEN-1:0] line_nxt,
   output logic [COL_LEN-1:0]  col_nxt,
   output logic                last_pixel
);

   localparam logic [COL_LEN-1:0]  COL_LAST  = COL_LEN'(H_ACTIVE - 1);
   localparam logic [LINE_LEN-1:0] LINE_LAST = LINE_LEN'(V_ACTIVE - 1);

   assign last_pixel = (line == LINE_LAST) && (col == COL_LAST);

   always_comb begin
      col_nxt  = col + COL_LEN'(1);
      line_nxt = line;
      if (col == COL_LAST) begin
         col_nxt  = '0;
         line_nxt = line + LINE_LEN'(1);
      end
   end

   // The last pixel never advances, so the counters stay inside the active frame.
   always_ff @(posedge PLB_clk or negedge reset_n) begin
      if (!reset_n) begin
         line <= '0;
         col  <= '0;
      end else if (clr) begin
         line <= '0;
         col  <= '0;
      end else if (inc && !last_pixel) begin
         line <= line_nxt;
         col  <= col_nxt;
      end
   end

endmodule

// File: rtl/fb_scanout_reader.sv
// PLB read master that scans the active frame out of the framebuffer.
// Each pixel is fetched with a single-beat read and pushed into the display FIFO.
module fb_scanout_reader
   import fb_pkg::*;
#(
   parameter int H_ACTIVE = fb_pkg::H_ACTIVE,
   parameter int V_ACTIVE = fb_pkg::V_ACTIVE
) (
   input  logic                    PLB_clk,
   input  logic                    reset_n,
   input  logic                    Bus2IP_Reset,
   input  logic                    enable,
   input  logic                    frame_start,
   output logic                    frame_done,
   output logic                    busy,
   output logic [7:0]              err_cnt,
   output logic [C_MST_DWIDTH-1:0] pix_data,
   output logic                    pix_wr_en,
   input  logic                    pix_full,
   output logic                    IP2Bus_MstRd_Req,
   output logic                    IP2Bus_MstWr_Req,
   output logic [C_MST_AWIDTH-1:0] IP2Bus_Mst_Addr,
   output logic [3:0]              IP2Bus_Mst_BE,
   output logic                    IP2Bus_Mst_Lock,
   output logic                    IP2Bus_Mst_Reset,
   output logic                    IP2Bus_MstRd_dst_rdy_n,
   output logic [C_MST_DWIDTH-1:0] IP2Bus_MstWr_d,
   input  logic                    Bus2IP_Mst_CmdAck,
   input  logic                    Bus2IP_Mst_Cmplt,
   input  logic                    Bus2IP_Mst_Error,
   input  logic                    Bus2IP_Mst_Rearbitrate,
   input  logic                    Bus2IP_Mst_Cmd_Timeout,
   input  logic [C_MST_DWIDTH-1:0] Bus2IP_MstRd_d,
   input  logic                    Bus2IP_MstRd_src_rdy_n,
   input  logic                    Bus2IP_MstWr_dst_rdy_n,
   output fb_state_t               dbg_state
);

   fb_state_t           state;
   logic                got_data;
   logic [LINE_LEN-1:0] line, line_nxt;
   logic [COL_LEN-1:0]  col, col_nxt;
   logic                last_pixel;
   logic                push_go;
   logic                unused_ok;

   // Handshakes: a command is issued by holding Req until CmdAck (Rearbitrate
   // leaves Req up); a data beat transfers on a cycle where dst_rdy_n and
   // src_rdy_n are both low; a FIFO push happens on a cycle with pix_wr_en high,
   // which is never raised while pix_full is high.
   assign push_go   = (state == PUSH) && !pix_full;
   assign pix_wr_en = push_go;
   assign busy      = (state != IDLE);
   assign dbg_state = state;

   assign IP2Bus_MstWr_Req = 1'b0;
   assign IP2Bus_Mst_BE    = 4'hF;
   assign IP2Bus_Mst_Lock  = 1'b0;
   assign IP2Bus_Mst_Reset = 1'b0;
   assign IP2Bus_MstWr_d   = '0;
   assign unused_ok        = &{1'b0, Bus2IP_Mst_Rearbitrate, Bus2IP_MstWr_dst_rdy_n};

   fb_scan_counter #(
      .H_ACTIVE (H_ACTIVE),
      .V_ACTIVE (V_ACTIVE)
   ) u_counter (
      .PLB_clk    (PLB_clk),
      .reset_n    (reset_n),
      .clr        (Bus2IP_Reset || (state == DONE)),
      .inc        (push_go),
      .line       (line),
      .col        (col),
      .line_nxt   (line_nxt),
      .col_nxt    (col_nxt),
      .last_pixel (last_pixel)
   );

   always_ff @(posedge PLB_clk or negedge reset_n) begin
      if (!reset_n) begin
         state                  <= IDLE;
         IP2Bus_MstRd_Req       <= 1'b0;
         IP2Bus_MstRd_dst_rdy_n <= 1'b1;
         IP2Bus_Mst_Addr        <= '0;
         pix_data               <= '0;
         got_data               <= 1'b0;
         frame_done             <= 1'b0;
         err_cnt                <= '0;
      end else if (Bus2IP_Reset) begin
         state                  <= IDLE;
         IP2Bus_MstRd_Req       <= 1'b0;
         IP2Bus_MstRd_dst_rdy_n <= 1'b1;
         IP2Bus_Mst_Addr        <= '0;
         pix_data               <= '0;
         got_data               <= 1'b0;
         frame_done             <= 1'b0;
         err_cnt                <= '0;
      end else begin
         frame_done <= 1'b0;
         case (state)
            IDLE: begin
               if (frame_start && enable) begin
                  state            <= REQ;
                  IP2Bus_MstRd_Req <= 1'b1;
                  IP2Bus_Mst_Addr  <= fb_addr(line, col);
               end
            end
            REQ: begin
               if (Bus2IP_Mst_Cmd_Timeout) begin
                  IP2Bus_MstRd_Req <= 1'b0;
                  state            <= ERR;
               end else if (Bus2IP_Mst_CmdAck) begin
                  IP2Bus_MstRd_Req       <= 1'b0;
                  IP2Bus_MstRd_dst_rdy_n <= 1'b0;
                  got_data               <= 1'b0;
                  state                  <= WAIT_DATA;
               end
            end
            WAIT_DATA: begin
               if (!Bus2IP_MstRd_src_rdy_n) begin
                  pix_data <= Bus2IP_MstRd_d;
                  got_data <= 1'b1;
               end
               // A beat arriving together with Cmplt still counts as data.
               if (Bus2IP_Mst_Cmplt) begin
                  IP2Bus_MstRd_dst_rdy_n <= 1'b1;
                  if ((got_data || !Bus2IP_MstRd_src_rdy_n) && !Bus2IP_Mst_Error)
                     state <= PUSH;
                  else
                     state <= ERR;
               end
            end
            ERR: begin
               if (err_cnt != 8'hFF)
                  err_cnt <= err_cnt + 8'd1;
               pix_data <= '0;
               state    <= PUSH;
            end
            PUSH: begin
               if (!pix_full) begin
                  if (last_pixel) begin
                     state      <= DONE;
                     frame_done <= 1'b1;
                  end else begin
                     state            <= REQ;
                     IP2Bus_MstRd_Req <= 1'b1;
                     IP2Bus_Mst_Addr  <= fb_addr(line_nxt, col_nxt);
                  end
               end
            end
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fb_scanout_reader.sv
// Randomised bench for fb_scanout_reader on a 4x2 frame with a reactive PLB slave.
// Expected pixels come from an address-arithmetic model and are checked by a separate monitor.
module tb_fb_scanout_reader;

   localparam int H = 4;
   localparam int V = 2;

   logic        PLB_clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        Bus2IP_Reset = 1'b0;
   logic        enable = 1'b1;
   logic        frame_start = 1'b0;
   logic        frame_done;
   logic        busy;
   logic [7:0]  err_cnt;
   logic [31:0] pix_data;
   logic        pix_wr_en;
   logic        pix_full = 1'b0;
   logic        IP2Bus_MstRd_Req;
   logic        IP2Bus_MstWr_Req;
   logic [31:0] IP2Bus_Mst_Addr;
   logic [3:0]  IP2Bus_Mst_BE;
   logic        IP2Bus_Mst_Lock;
   logic        IP2Bus_Mst_Reset;
   logic        IP2Bus_MstRd_dst_rdy_n;
   logic [31:0] IP2Bus_MstWr_d;
   logic        Bus2IP_Mst_CmdAck = 1'b0;
   logic        Bus2IP_Mst_Cmplt = 1'b0;
   logic        Bus2IP_Mst_Error = 1'b0;
   logic        Bus2IP_Mst_Rearbitrate = 1'b0;
   logic        Bus2IP_Mst_Cmd_Timeout = 1'b0;
   logic [31:0] Bus2IP_MstRd_d = '0;
   logic        Bus2IP_MstRd_src_rdy_n = 1'b1;
   logic        Bus2IP_MstWr_dst_rdy_n = 1'b1;
   fb_pkg::fb_state_t dbg_state;

   logic [31:0] exp_q[$];
   logic [31:0] addr_q[$];
   int          plan_q[$];
   int n_cmp = 0, n_fail = 0;
   int exp_err = 0, exp_frames = 0, done_seen = 0, serves_done = 0;
   int force_mode = -1;
   bit slave_en = 1'b1, full_rand = 1'b0;

   fb_scanout_reader #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
      .PLB_clk(PLB_clk), .reset_n(reset_n), .Bus2IP_Reset(Bus2IP_Reset),
      .enable(enable), .frame_start(frame_start), .frame_done(frame_done),
      .busy(busy), .err_cnt(err_cnt), .pix_data(pix_data), .pix_wr_en(pix_wr_en),
      .pix_full(pix_full), .IP2Bus_MstRd_Req(IP2Bus_MstRd_Req),
      .IP2Bus_MstWr_Req(IP2Bus_MstWr_Req), .IP2Bus_Mst_Addr(IP2Bus_Mst_Addr),
      .IP2Bus_Mst_BE(IP2Bus_Mst_BE), .IP2Bus_Mst_Lock(IP2Bus_Mst_Lock),
      .IP2Bus_Mst_Reset(IP2Bus_Mst_Reset), .IP2Bus_MstRd_dst_rdy_n(IP2Bus_MstRd_dst_rdy_n),
      .IP2Bus_MstWr_d(IP2Bus_MstWr_d), .Bus2IP_Mst_CmdAck(Bus2IP_Mst_CmdAck),
      .Bus2IP_Mst_Cmplt(Bus2IP_Mst_Cmplt), .Bus2IP_Mst_Error(Bus2IP_Mst_Error),
      .Bus2IP_Mst_Rearbitrate(Bus2IP_Mst_Rearbitrate),
      .Bus2IP_Mst_Cmd_Timeout(Bus2IP_Mst_Cmd_Timeout), .Bus2IP_MstRd_d(Bus2IP_MstRd_d),
      .Bus2IP_MstRd_src_rdy_n(Bus2IP_MstRd_src_rdy_n),
      .Bus2IP_MstWr_dst_rdy_n(Bus2IP_MstWr_dst_rdy_n), .dbg_state(dbg_state)
   );

   // clock / reset
   always #5 PLB_clk = ~PLB_clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic flag(input string name);
      n_cmp++;
      n_fail++;
      $display("FAIL %s", name);
   endtask

   function automatic logic [31:0] model_addr(input int l, input int c);
      return 32'h9000_0000 + 32'(l * 4096) + 32'(c * 4);
   endfunction

   function automatic int sat_inc(input int v);
      return (v >= 255) ? 255 : v + 1;
   endfunction

   task automatic tick();
      @(posedge PLB_clk);
      #1;
   endtask

   // driver tasks
   task automatic pulse_start();
      tick();
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
   endtask

   task automatic start_frame();
      for (int l = 0; l < V; l++)
         for (int c = 0; c < H; c++)
            addr_q.push_back(model_addr(l, c));
      exp_frames++;
      pulse_start();
   endtask

   task automatic wait_done();
      int budget = 4000;
      while (done_seen < exp_frames && budget > 0) begin
         tick();
         budget--;
      end
      if (done_seen < exp_frames) flag("frame_done timeout");
      tick();
      check("busy after frame", 32'(busy), 32'd0);
      check("err_cnt after frame", 32'(err_cnt), 32'(exp_err));
   endtask

   // Reactive PLB slave. Modes: 0 data then Cmplt, 1 data with Cmplt,
   // 2 data then Cmplt+Error, 3 Cmd_Timeout, 4 Cmplt without data.
   task automatic serve();
      logic [31:0] a;
      int mode, d;
      if (addr_q.size() == 0) begin
         flag("read with no pixel pending");
         a = 32'hDEAD_BEEF;
      end else begin
         a = addr_q.pop_front();
      end
      check("req addr", IP2Bus_Mst_Addr, a);
      if (plan_q.size() > 0) mode = plan_q.pop_front();
      else if (force_mode >= 0) mode = force_mode;
      else begin
         mode = $urandom_range(0, 6);
         if (mode > 4) mode = 0;
      end
      exp_q.push_back((mode <= 1) ? a : 32'h0);
      if (mode >= 2) exp_err = sat_inc(exp_err);
      d = $urandom_range(0, 5);
      for (int i = 0; i < d; i++) begin
         Bus2IP_Mst_Rearbitrate = (i == 0);
         tick();
         Bus2IP_Mst_Rearbitrate = 1'b0;
         check("req held until ack", 32'(IP2Bus_MstRd_Req), 32'd1);
      end
      if (mode == 3) Bus2IP_Mst_Cmd_Timeout = 1'b1;
      else Bus2IP_Mst_CmdAck = 1'b1;
      tick();
      Bus2IP_Mst_Cmd_Timeout = 1'b0;
      Bus2IP_Mst_CmdAck = 1'b0;
      check("req drop after ack", 32'(IP2Bus_MstRd_Req), 32'd0);
      if (mode != 3) begin
         check("dst_rdy_n in data phase", 32'(IP2Bus_MstRd_dst_rdy_n), 32'd0);
         if (mode == 0 || mode == 2) begin
            repeat ($urandom_range(0, 2)) tick();
            Bus2IP_MstRd_src_rdy_n = 1'b0;
            Bus2IP_MstRd_d = IP2Bus_Mst_Addr;
            tick();
            Bus2IP_MstRd_src_rdy_n = 1'b1;
            Bus2IP_MstRd_d = $urandom;
            repeat ($urandom_range(0, 2)) tick();
         end
         check("addr stable to cmplt", IP2Bus_Mst_Addr, a);
         Bus2IP_Mst_Cmplt = 1'b1;
         Bus2IP_Mst_Error = (mode == 2);
         if (mode == 1) begin
            Bus2IP_MstRd_src_rdy_n = 1'b0;
            Bus2IP_MstRd_d = IP2Bus_Mst_Addr;
         end
         tick();
         Bus2IP_Mst_Cmplt = 1'b0;
         Bus2IP_Mst_Error = 1'b0;
         Bus2IP_MstRd_src_rdy_n = 1'b1;
         check("dst_rdy_n after cmplt", 32'(IP2Bus_MstRd_dst_rdy_n), 32'd1);
      end
      if (!full_rand && !pix_full)
         check("push one cycle after cmplt", 32'(pix_wr_en), (mode <= 1) ? 32'd1 : 32'd0);
      serves_done++;
   endtask

   initial begin
      forever begin
         tick();
         if (slave_en && IP2Bus_MstRd_Req) serve();
      end
   end

   initial begin
      forever begin
         tick();
         if (full_rand) pix_full = ($urandom_range(0, 3) == 0);
      end
   end

   // scoreboard monitor
   always @(negedge PLB_clk) begin
      if (pix_wr_en) begin
         if (pix_full) flag("push while pix_full");
         if (exp_q.size() == 0) flag("unexpected push");
         else check("pixel data", pix_data, exp_q.pop_front());
      end
      if (frame_done) begin
         done_seen++;
         check("frame_done after last pixel", 32'(exp_q.size() + addr_q.size()), 32'd0);
      end
   end

   initial begin
      int base, budget;
      repeat (3) @(posedge PLB_clk);
      #1 reset_n = 1'b1;
      @(negedge PLB_clk);
      check("reset req", 32'(IP2Bus_MstRd_Req), 32'd0);
      check("reset dst_rdy_n", 32'(IP2Bus_MstRd_dst_rdy_n), 32'd1);
      check("reset wr_en", 32'(pix_wr_en), 32'd0);
      check("reset busy", 32'(busy), 32'd0);
      check("reset done", 32'(frame_done), 32'd0);
      check("reset err_cnt", 32'(err_cnt), 32'd0);
      check("reset addr", IP2Bus_Mst_Addr, 32'd0);
      check("reset pix_data", pix_data, 32'd0);
      check("reset state", 32'(dbg_state), 32'(fb_pkg::IDLE));
      check("tied wr_req", 32'(IP2Bus_MstWr_Req), 32'd0);
      check("tied be", 32'(IP2Bus_Mst_BE), 32'hF);
      check("tied lock/reset/wr_d", {IP2Bus_MstWr_d[29:0], IP2Bus_Mst_Lock, IP2Bus_Mst_Reset}, 32'd0);

      // clean frame: data equals address, in raster order
      for (int i = 0; i < H * V; i++) plan_q.push_back(0);
      start_frame();
      wait_done();

      // error on the third pixel, random ack delays with rearbitrate
      for (int i = 0; i < H * V; i++) plan_q.push_back((i == 2) ? 2 : 0);
      start_frame();
      wait_done();

      // FIFO full stall on the first pixel
      pix_full = 1'b1;
      plan_q.push_back(0);
      base = serves_done;
      start_frame();
      budget = 200;
      while (serves_done == base && budget > 0) begin
         tick();
         budget--;
      end
      if (serves_done == base) flag("stall read timeout");
      repeat (10) begin
         @(negedge PLB_clk);
         check("stall no req", 32'(IP2Bus_MstRd_Req), 32'd0);
         check("stall pix_data held", pix_data, (exp_q.size() > 0) ? exp_q[0] : 32'hFFFF_FFFF);
      end
      tick();
      pix_full = 1'b0;
      wait_done();

      // async reset in the data phase
      slave_en = 1'b0;
      pulse_start();
      budget = 20;
      while (!IP2Bus_MstRd_Req && budget > 0) begin
         tick();
         budget--;
      end
      check("manual req", 32'(IP2Bus_MstRd_Req), 32'd1);
      Bus2IP_Mst_CmdAck = 1'b1;
      tick();
      Bus2IP_Mst_CmdAck = 1'b0;
      check("manual dst_rdy_n", 32'(IP2Bus_MstRd_dst_rdy_n), 32'd0);
      #2 reset_n = 1'b0;
      #1;
      check("async reset req", 32'(IP2Bus_MstRd_Req), 32'd0);
      check("async reset dst_rdy_n", 32'(IP2Bus_MstRd_dst_rdy_n), 32'd1);
      check("async reset busy", 32'(busy), 32'd0);
      tick();
      reset_n = 1'b1;
      exp_err = 0;
      slave_en = 1'b1;
      start_frame();
      wait_done();

      // ignored starts: enable low while idle, start while busy, enable dropped mid-frame
      enable = 1'b0;
      pulse_start();
      repeat (4) tick();
      check("start ignored when disabled", 32'({busy, IP2Bus_MstRd_Req}), 32'd0);
      enable = 1'b1;
      start_frame();
      repeat (12) tick();
      pulse_start();
      repeat (3) tick();
      enable = 1'b0;
      wait_done();
      enable = 1'b1;

      // random frames, half with random FIFO back-pressure
      for (int f = 0; f < 10; f++) begin
         full_rand = (f >= 5);
         start_frame();
         wait_done();
      end
      full_rand = 1'b0;
      tick();
      pix_full = 1'b0;

      // synchronous IPIF reset clears the error count
      Bus2IP_Reset = 1'b1;
      tick();
      Bus2IP_Reset = 1'b0;
      exp_err = 0;
      check("sync reset err_cnt", 32'(err_cnt), 32'd0);

      // error counter saturation
      force_mode = 3;
      for (int f = 0; f < 33; f++) begin
         start_frame();
         wait_done();
      end
      force_mode = -1;
      check("err_cnt saturated", 32'(err_cnt), 32'd255);
      check("frame_done count", 32'(done_seen), 32'(exp_frames));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global timeout");
      $fatal(1, "timeout");
   end

endmodule
